alu_result_fifo: RTL and testbench

Downstream capture stage for the 8-bit ALU wrapper. Samples the wrapper's `data_out` byte once per `output_done` rising edge and queues results in a small circular FIFO. Results drain through a first-word-fall-through valid/ready port toward the consumer (UART TX, logger or checker). Reports fill level and overflow so lost results are never silent.

---
 rtl/alu_result_fifo.sv | 83 ++++++++
 tb/tb_alu_result_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// Capture FIFO for ALU results: one push per res_done rising edge, FWFT valid/ready drain.
// Define ALU_RESFIFO_STICKY_OVF_EN to make `overflow` sticky until reset (default: one-cycle pulse).
module alu_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         res_in,
    input  logic                     res_done,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [AW:0]      count_q, count_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             push, pop, wr_en, drop;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign out_valid = ~empty;
    assign out_data  = mem_q[rp_q];
    assign count     = count_q;
    assign overflow  = ovf_q;

    always_comb begin
        done_d  = res_done;
        push    = res_done & ~done_q;
        pop     = out_valid & out_ready;
        // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
        wr_en   = push & (~full | pop);
        drop    = push & ~wr_en;
        wp_d    = wr_en ? wp_q + 1'b1 : wp_q;
        rp_d    = pop ? rp_q + 1'b1 : rp_q;
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
`ifdef ALU_RESFIFO_STICKY_OVF_EN
        ovf_d = ovf_q | drop;
`else
        ovf_d = drop;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wp_q] <= res_in;
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: directed test-plan cases plus random traffic vs a queue model.
module tb_alu_result_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] res_in = '0;
    logic             res_done = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [3:0]       count;
    logic             full, empty, overflow;

    alu_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .res_in(res_in), .res_done(res_done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .full(full), .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model
    logic [7:0] m_q[$];
    logic       m_done = 1'b0;
    logic       m_ovf  = 1'b0;
    int         ovf_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_done = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_edge();
        logic push, pop, drop;
        if (rst) begin
            model_reset();
        end else begin
            push = res_done && !m_done;
            pop  = (m_q.size() != 0) && out_ready;
            drop = push && (m_q.size() == DEPTH) && !pop;
            if (pop) void'(m_q.pop_front());
            if (push && !drop) m_q.push_back(res_in);
            m_done = res_done;
`ifdef ALU_RESFIFO_STICKY_OVF_EN
            m_ovf = m_ovf | drop;
`else
            m_ovf = drop;
`endif
        end
    endtask

    task automatic check_all();
        check("count", 32'(count), 32'(m_q.size()));
        check("empty", 32'(empty), 32'(m_q.size() == 0));
        check("full", 32'(full), 32'(m_q.size() == DEPTH));
        check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (m_q.size() != 0) check("out_data", 32'(out_data), 32'(m_q[0]));
        if (overflow) ovf_seen++;
    endtask

    // Called at a negedge: drive inputs, advance one edge, check at the next negedge.
    task automatic cycle(input logic d, input logic [7:0] v, input logic rdy);
        res_done  = d;
        res_in    = v;
        out_ready = rdy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic push_one(input logic [7:0] v);
        cycle(1'b1, v, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin
            if (m_q.size() == 0) break;
            cycle(1'b0, 8'h00, 1'b1);
        end
        check("drained", 32'(m_q.size()), 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic async_reset_check(input logic d, input logic rdy);
        res_done  = d;
        out_ready = rdy;
        #2 rst = 1'b1;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        model_reset();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all();

        // Mid-cycle reset with res_done held high; a push follows release
        cycle(1'b0, 8'h00, 1'b0);
        async_reset_check(1'b1, 1'b0);
        cycle(1'b1, 8'h77, 1'b0);
        check("post_rst_push", 32'(count), 32'd1);
        cycle(1'b0, 8'h00, 1'b0);
        drain();

        // Level-held res_done gives one push
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check("single_count", 32'(count), 32'd1);
        check("single_data", 32'(out_data), 32'h3C);
        drain();

        // Fill, drain in order, then wrap
        for (int i = 1; i <= 8; i++) push_one(8'(i));
        check("fill_full", 32'(full), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            check("fill_order", 32'(out_data), 32'(i));
            cycle(1'b0, 8'h00, 1'b1);
        end
        push_one(8'h09);
        push_one(8'h0A);
        check("wrap_head", 32'(out_data), 32'h09);
        cycle(1'b0, 8'h00, 1'b1);
        check("wrap_next", 32'(out_data), 32'h0A);
        drain();

        // Overflow: push onto full FIFO is dropped
        for (int i = 0; i < 8; i++) push_one(8'h10 + 8'(i));
        ovf_seen = 0;
        cycle(1'b1, 8'hFF, 1'b0);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
`ifdef ALU_RESFIFO_STICKY_OVF_EN
        check("ovf_sticky", 32'(overflow), 32'd1);
`else
        check("ovf_pulse_len", 32'(ovf_seen), 32'd1);
`endif
        for (int i = 0; i < 8; i++) begin
            check("ovf_no_ff", 32'(out_data != 8'hFF), 32'd1);
            cycle(1'b0, 8'h00, 1'b1);
        end

        // Full with simultaneous push and pop
        async_reset_check(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) push_one(8'h20 + 8'(i));
        cycle(1'b1, 8'hAA, 1'b1);
        check("pp_count", 32'(count), 32'd8);
        check("pp_ovf", 32'(overflow), 32'd0);
        check("pp_head", 32'(out_data), 32'h21);
        for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1);
        check("pp_last", 32'(out_data), 32'hAA);
        drain();

        // Reset mid-drain
        for (int i = 0; i < 4; i++) push_one(8'h40 + 8'(i));
        cycle(1'b0, 8'h00, 1'b1);
        async_reset_check(1'b0, 1'b1);
        out_ready = 1'b0;
        push_one(8'h55);
        check("rst_drain_first", 32'(out_data), 32'h55);
        drain();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom),
                  (i % 400) < 200 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
